fir_result_uart_tx: RTL

Serializes one signed FIR filter result onto the UART transmit line as a fixed-length sequence of 8N1 bytes, least-significant byte first. It sits between the filter's output register and the board TX pin and is the return path of the UART-based filter. It accepts a result on a valid/ready handshake, transmits it, and pulses `done`; it never drops or reorders an accepted result.

---
 rtl/fir_result_uart_tx_if.sv | 20 ++
 rtl/fir_result_uart_tx.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fir_result_uart_tx_if.sv
// Result handshake between the FIR output register and the UART return path.
interface fir_result_uart_tx_if #(
  parameter int output_width = 38
);
  logic [output_width-1:0] in;
  logic                    in_valid;
  logic                    in_ready;

  modport master (
    output in,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/fir_result_uart_tx.sv
// Sends one signed FIR result as LSB-first UART bytes (8N1, or 8E1 when
// FIR_TX_PARITY_EN is defined); pulses done after the last stop bit.
module fir_result_uart_tx #(
  parameter int output_width = 38,
  parameter int clks_per_bit = 434
) (
  input  logic                 clock,
  input  logic                 reset_n,
  fir_result_uart_tx_if.slave  res,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);
  localparam int byte_count = (output_width + 7) / 8;
  localparam int SW = byte_count * 8;
  localparam int BW = $clog2(clks_per_bit);
  localparam int NW = $clog2(byte_count + 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [NW-1:0]   byte_q, byte_d;
  logic [SW-1:0]   sh_q, sh_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;

  logic signed [output_width-1:0] in_s;
  logic            bit_end;
  logic            last_byte;
  logic [7:0]      cur;
  logic [2:0]      bit_nx;

  assign in_s      = res.in;
  assign bit_end   = (baud_q == BW'(clks_per_bit - 1));
  assign last_byte = (byte_q == NW'(byte_count - 1));
  assign cur       = sh_q[7:0];
  assign bit_nx    = bit_q + 3'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    sh_d    = sh_q;
    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + BW'(1);
    end
    case (state_q)
      IDLE: begin
        if (res.in_valid) begin
          state_d = START;
          sh_d    = SW'(in_s);
          byte_d  = '0;
          bit_d   = '0;
          baud_d  = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_d = bit_nx;
          if (bit_q == 3'd7) begin
`ifdef FIR_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          sh_d = sh_q >> 8;
          if (last_byte) begin
            state_d = IDLE;
          end else begin
            state_d = START;
            byte_d  = byte_q + NW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is registered, so it is loaded with the level of the upcoming bit
  always_comb begin
    tx_d   = tx_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (res.in_valid) tx_d = 1'b0;
      end
      START: begin
        if (bit_end) tx_d = cur[0];
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef FIR_TX_PARITY_EN
            tx_d = ^cur;
`else
            tx_d = 1'b1;
`endif
          end else begin
            tx_d = cur[bit_nx];
          end
        end
      end
      PARITY: begin
        if (bit_end) tx_d = 1'b1;
      end
      STOP: begin
        if (bit_end) begin
          tx_d   = last_byte;
          done_d = last_byte;
        end
      end
      default: tx_d = 1'b1;
    endcase
  end

  assign tx           = tx_q;
  assign done         = done_q;
  assign busy         = (state_q != IDLE);
  assign res.in_ready = (state_q == IDLE);
endmodule
